// File: rtl/product_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_display_if
// Description : Bundle between a product source and the BCD display block.
//               Carries the load strobe and product, plus the busy flag,
//               held BCD result, result-valid pulse and the 7-segment pins.
//   load        product valid strobe (source -> display)
//   product     16-bit unsigned value to convert (source -> display)
//   busy        conversion in progress (display -> source)
//   bcd         held result {d4,d3,d2,d1,d0} (display -> source)
//   bcd_valid   one-cycle pulse when bcd updates (display -> source)
//   seg_display active-low segments {g,f,e,d,c,b,a} (display -> pins)
//   an          active-low digit enables, an[i] selects di (display -> pins)
// Revision    : 1.0 - initial release
// ============================================================================
interface product_bcd_display_if;
    logic        load;
    logic [15:0] product;
    logic        busy;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg_display;
    logic [4:0]  an;

    modport master (
        output load, product,
        input  busy, bcd, bcd_valid, seg_display, an
    );

    modport slave (
        input  load, product,
        output busy, bcd, bcd_valid, seg_display, an
    );
endinterface
`default_nettype wire

// File: rtl/product_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_display
// Description : Captures a 16-bit product on a load strobe, converts it to
//               five packed BCD digits with a one-shift-per-clock
//               double-dabble engine, and scans the held result onto a
//               multiplexed active-low 7-segment display.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - product_bcd_display_if.slave (load, product, busy,
//                       bcd, bcd_valid, seg_display, an)
// Parameters  : REFRESH_DIV - cycles each digit stays enabled (>= 2)
// Macros      : LEADING_ZERO_BLANK_EN - blank digits above the most
//               significant nonzero digit (d0 never blanked)
// Revision    : 1.0 - initial release
// ============================================================================
module product_bcd_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    product_bcd_display_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_sreg;
    logic [19:0] r_scratch;
    logic [3:0]  r_count;
    logic        r_busy;
    logic [19:0] r_bcd;
    logic        r_bcd_valid;

    logic [CNT_W-1:0] r_refresh;
    logic [2:0]       r_index;
    logic [4:0]       r_an;
    logic [6:0]       r_seg;

    logic [19:0] w_adj;
    logic [35:0] w_shift;
    logic        w_wrap;
    logic [2:0]  w_next_index;
    logic [3:0]  w_digit;
    logic        w_blank;

    // ---------------------------------------------------------------------
    // Double-dabble: add-3 correction on every nibble >= 5, then shift the
    // concatenated {scratch, shift register} left by one.
    // ---------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 5; i++) begin : g_adj
            assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5)
                                   ? r_scratch[4*i +: 4] + 4'd3
                                   : r_scratch[4*i +: 4];
        end
    endgenerate

    assign w_shift = {w_adj, r_sreg} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_scratch   <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_sreg    <= bus.product;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shift[35:16];
                    r_sreg    <= w_shift[15:0];
                    r_count   <= r_count + 4'd1;
                    // Sixteenth shift: the shifted scratch is the final result.
                    if (r_count == 4'd15) begin
                        r_bcd       <= w_shift[35:16];
                        r_bcd_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Display scan. Segments are re-registered every cycle from the index
    // the anode register will hold, so an and seg_display always agree and
    // both step together on the refresh wrap.
    // ---------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        w_wrap       = (r_refresh == CNT_W'(REFRESH_DIV - 1));
        w_next_index = r_index;
        if (w_wrap) begin
            w_next_index = (r_index == 3'd4) ? 3'd0 : r_index + 3'd1;
        end
        w_digit = r_bcd[4*w_next_index +: 4];
        w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are 0.
        case (w_next_index)
            3'd1:    w_blank = (r_bcd[19:4]  == 16'd0);
            3'd2:    w_blank = (r_bcd[19:8]  == 12'd0);
            3'd3:    w_blank = (r_bcd[19:12] == 8'd0);
            3'd4:    w_blank = (r_bcd[19:16] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_index   <= '0;
            r_an      <= 5'b11110;
            r_seg     <= 7'b1000000;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + CNT_W'(1);
            r_index   <= w_next_index;
            r_an      <= ~(5'b00001 << w_next_index);
            r_seg     <= w_blank ? 7'h7F : decode(w_digit);
        end
    end

    assign bus.busy        = r_busy;
    assign bus.bcd         = r_bcd;
    assign bus.bcd_valid   = r_bcd_valid;
    assign bus.seg_display = r_seg;
    assign bus.an          = r_an;

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_bcd_display
// Description : Directed self-checking bench for product_bcd_display with
//               REFRESH_DIV = 4. Honours LEADING_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_bcd_display;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    product_bcd_display_if bus ();

    product_bcd_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [19:0] v, input int i);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (v >> (4*i)) == 20'd0) return 7'h7F;
`endif
        return seg_of(v[4*i +: 4]);
    endfunction

    // Drives load for one edge, then checks busy through the 16 shifts and
    // the single bcd_valid cycle. Returns at the bcd_valid cycle.
    task automatic run_conv(input logic [15:0] p, input logic [19:0] exp, input string tag);
        bus.load    = 1'b1;
        bus.product = p;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"},  32'(bus.busy), 32'd1);
            chk({tag, "_nvld"},  32'(bus.bcd_valid), 32'd0);
            tick();
        end
        chk({tag, "_vld"},  32'(bus.bcd_valid), 32'd1);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_bcd"},  32'(bus.bcd), 32'(exp));
    endtask

    // Aligns to the start of digit 0 and checks one full 20-cycle scan.
    task automatic check_scan(input logic [19:0] v, input string tag);
        logic [4:0] prev;
        bit         found;
        found = 1'b0;
        prev  = bus.an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev == 5'b01111 && bus.an == 5'b11110) found = 1'b1;
            else prev = bus.an;
        end
        chk({tag, "_sync"}, 32'(found), 32'd1);
        for (int c = 0; c < 20; c++) begin
            chk({tag, "_an"},  32'(bus.an), 32'(~(5'b00001 << (c/4)) & 5'h1F));
            chk({tag, "_seg"}, 32'(bus.seg_display), 32'(exp_seg(v, c/4)));
            if (c < 19) tick();
        end
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.product = 16'd0;
        reset       = 1'b1;
        tick(); tick(); tick();

        // Reset state (checked while reset is still asserted)
        chk("rst_an",   32'(bus.an), 32'h1E);
        chk("rst_seg",  32'(bus.seg_display), 32'h40);
        chk("rst_bcd",  32'(bus.bcd), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_vld",  32'(bus.bcd_valid), 32'd0);
        reset = 1'b0;

        // 150 -> 00150, single valid pulse
        run_conv(16'd150, 20'h00150, "p150");
        tick();
        chk("p150_pulse_end", 32'(bus.bcd_valid), 32'd0);
        chk("p150_hold",      32'(bus.bcd), 32'h00150);

        // 65535 then 0 loaded in the bcd_valid cycle
        run_conv(16'd65535, 20'h65535, "pmax");
        run_conv(16'd0, 20'h00000, "pzero");
        tick();
        chk("pzero_pulse_end", 32'(bus.bcd_valid), 32'd0);
        chk("pzero_no_rerun",  32'(bus.busy), 32'd0);

        check_scan(20'h00000, "scan0");

        // 42 with a 999 load issued mid-conversion, which must be ignored
        tick();
        bus.load    = 1'b1;
        bus.product = 16'd42;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("p42_busy", 32'(bus.busy), 32'd1);
            if (i == 5) begin
                bus.load    = 1'b1;
                bus.product = 16'd999;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;
        chk("p42_vld", 32'(bus.bcd_valid), 32'd1);
        chk("p42_bcd", 32'(bus.bcd), 32'h00042);
        tick();
        chk("p42_no_queue", 32'(bus.busy), 32'd0);
        chk("p42_pulse_end", 32'(bus.bcd_valid), 32'd0);

        check_scan(20'h00042, "scan42");

        tick();
        run_conv(16'd12345, 20'h12345, "p12345");
        check_scan(20'h12345, "scan12345");

        // Reset mid-conversion aborts it
        tick();
        bus.load    = 1'b1;
        bus.product = 16'd777;
        tick();
        bus.load = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("abort_bcd",  32'(bus.bcd), 32'd0);
            chk("abort_vld",  32'(bus.bcd_valid), 32'd0);
            chk("abort_busy", 32'(bus.busy), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
